dbg_ctl_mbp: RTL
================

# dbg_ctl_mbp

Multi-breakpoint debug controller for the NaiveMIPS CPU core, the next generation of the single-breakpoint debugger. It sits between the host debug link (command/parameter/result port) and the pipeline. It compares the issuing instruction PC against `NUM_BP` independently enabled breakpoint slots and supports counted single-step. When it halts, it flushes and stalls the pipeline, records a halt reason, and serves register, HI/LO, PC and instruction-memory reads to the host.

## Interface
Parameters:
- `NUM_BP`, default 4, number of breakpoint slots (1..16).
- `STEP_W`, default 16, width of the step counter.
- `DRAIN_CYCLES`, default 1, stall cycles spent in DRAIN before STOPPED (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_pc_value`  in  32  PC of the instruction currently eligible for trap.
- `inst_in_delayslot`  in  1  that instruction is in a branch delay slot.
- `new_pc_value`  out  32  restart PC after flush; equals `inst_pc_value`.
- `flush`  out  1  combinational pipeline flush.
- `debug_stall`  out  1  combinational pipeline stall.
- `main_reg_addr`, `cp0_reg_addr`  out  5  `host_param[4:0]`.
- `main_reg_value`, `cp0_reg_value`  in  32  register read data.
- `hilo_reg_value`  in  64  {HI, LO}.
- `pc_reg_value`  in  32  fetch PC.
- `pc_reset`  out  1  one-cycle PC reset pulse.
- `debugger_mem_read`  out  1  `host_cmd_en` && `host_cmd`==0x8c.
- `debugger_mem_addr`  out  32  `host_param`.
- `debugger_mem_data`  in  32  memory read data.
- `host_cmd`  in  8  command code.
- `host_param`  in  32  command parameter.
- `host_cmd_en`  in  1  command strobe; at most one command per cycle.
- `host_result`  out  32  registered result.

## Operation
Commands, accepted while `host_cmd_en` is high:
- 0x01 STOP
- 0x02 CONT
- 0x03 BP_MASK: enable mask ← `param[NUM_BP-1:0]`
- 0x04 BP_SEL: selected slot ← `param[3:0]`; indices ≥ `NUM_BP` are ignored
- 0x85 SET_BP: selected slot address ← `param`
- 0x86 READ_REG
- 0x87 READ_CP0
- 0x08 READ_HI
- 0x09 READ_LO
- 0x0a READ_PC
- 0x0b RESET: `pc_reset` pulse
- 0x8c READ_IMEM
- 0x0d STEP: count ← `param[STEP_W-1:0]`; 0 is treated as 1
- 0x0e QUERY: result = {16'b0, hit_idx[7:0], reason[2:0], state[4:0]}
- Any other code is a no-op with result 0.

Matching rules:
- `bp_hit` = OR over slots of (enable[i] && addr[i]==`inst_pc_value`).
- `hit_idx` is the lowest matching slot.
- `step_trig` = `inst_pc_value`≠0 && `inst_pc_value`≠`last_pc` && !`inst_in_delayslot`.

Halt reason codes: 0 none, 1 host stop, 2 breakpoint, 3 step done.

States, encoded 0..5: RUN, TRIGGER, DRAIN, STOPPED, STEP, STEP_DONE.
- RUN: on `bp_hit` or a stop request, assert `flush` and go to TRIGGER. Latch the reason; breakpoint wins over a simultaneous stop. Latch `hit_idx`.
- TRIGGER: stall, then go to DRAIN.
- DRAIN: stall for `DRAIN_CYCLES` cycles, then go to STOPPED.
- STOPPED: stall.
  - CONT: go to RUN and clear the reason.
  - STEP: load `step_cnt`, set `last_pc` ← `pc_reg_value`, go to STEP.
- STEP: pipeline runs.
  - `step_trig` with `step_cnt`>1: decrement, `last_pc` ← `inst_pc_value`, no flush.
  - `step_trig` with `step_cnt`==1: flush, reason 3, go to STEP_DONE.
  - `bp_hit` or a stop request aborts the step: flush, reason 2/1, go to TRIGGER. Breakpoint takes priority over step_trig.
- STEP_DONE: stall, then go to DRAIN.
- CONT or STEP outside STOPPED is ignored. STOP outside RUN/STEP is ignored.

## Timing
- Reset values:
  - state RUN, reason 0, `hit_idx` 0, enable mask 0.
  - All slot addresses 0xffffffff, selected slot 0.
  - `step_cnt` 0, `last_pc` 0.
  - `host_result` 0, `pc_reset` 0.
  - `flush`=0 and `debug_stall`=0.
- Command decode is registered:
  - Control commands (STOP/CONT/STEP) take effect on the state machine one cycle after the strobe.
  - `host_result` is valid exactly one cycle after the strobe and returns to 0 the following cycle.
  - `pc_reset` is high for that single cycle.
- `flush` and `debug_stall` are combinational from state and current inputs, and are never both high.
- Halt latency from a breakpoint match:
  - `flush` asserts in the same cycle as the match.
  - `debug_stall` is continuous from the next cycle.
  - STOPPED is reached after 1+`DRAIN_CYCLES` cycles.
- Asserting `rst` at any time returns immediately to RUN with stall released.

## Configuration
- `DBG_CYCLE_CNT_EN` defined:
  - Adds a 32-bit cycle counter that increments on every cycle with `debug_stall`=0 and wraps at 0xffffffff→0.
  - Command 0x0f returns the counter; command 0x10 clears it.
- Not defined: no counter logic exists, and 0x0f/0x10 are no-ops returning 0.

## Test plan
- Breakpoint slot: BP_SEL 2, SET_BP 0x80000010, BP_MASK 0x4; drive PC 0x80000010 → `flush` the same cycle, stall from the next, QUERY returns 0x00000243 (hit_idx 2, reason 2, state 3).
- Disabled slot: BP_MASK 0x0 with a matching PC → no flush, state stays 0.
- Counted step: from STOPPED, STEP param 3; feed PCs 0x100, 0x104 (delay slot), 0x108, 0x10c → flush only on 0x10c, QUERY reason 3.
- Step interrupted by breakpoint: STEP 5 with a breakpoint at the second eligible PC → abort, reason 2; CONT then returns to RUN with reason 0.
- Reads and reset: READ_HI with hilo=0x1122334455667788 → result 0x11223344 one cycle later, then 0; RESET → `pc_reset` 1-cycle pulse; `rst` asserted mid-DRAIN → state RUN, stall 0.
- With `DBG_CYCLE_CNT_EN`: run 10 unstalled cycles, then 0x0f → 10 (±command latency); 0x10 then 0x0f → 0 during STOPPED.

Source files
------------

// File: rtl/dbg_ctl_mbp_if.sv
// dbg_ctl_mbp_if: host debug link and pipeline signals of the multi-breakpoint
// debug controller, bundled so the controller and its environment share one port.
interface dbg_ctl_mbp_if;
    logic [31:0] inst_pc_value;
    logic        inst_in_delayslot;
    logic [31:0] new_pc_value;
    logic        flush;
    logic        debug_stall;
    logic [4:0]  main_reg_addr;
    logic [4:0]  cp0_reg_addr;
    logic [31:0] main_reg_value;
    logic [31:0] cp0_reg_value;
    logic [63:0] hilo_reg_value;
    logic [31:0] pc_reg_value;
    logic        pc_reset;
    logic        debugger_mem_read;
    logic [31:0] debugger_mem_addr;
    logic [31:0] debugger_mem_data;
    logic [7:0]  host_cmd;
    logic [31:0] host_param;
    logic        host_cmd_en;
    logic [31:0] host_result;

    // Controller side: consumes pipeline state and host commands.
    modport slave (
        input  inst_pc_value, inst_in_delayslot, main_reg_value, cp0_reg_value,
               hilo_reg_value, pc_reg_value, debugger_mem_data,
               host_cmd, host_param, host_cmd_en,
        output new_pc_value, flush, debug_stall, main_reg_addr, cp0_reg_addr,
               pc_reset, debugger_mem_read, debugger_mem_addr, host_result
    );

    // Environment side: pipeline plus host link.
    modport master (
        output inst_pc_value, inst_in_delayslot, main_reg_value, cp0_reg_value,
               hilo_reg_value, pc_reg_value, debugger_mem_data,
               host_cmd, host_param, host_cmd_en,
        input  new_pc_value, flush, debug_stall, main_reg_addr, cp0_reg_addr,
               pc_reset, debugger_mem_read, debugger_mem_addr, host_result
    );
endinterface

// File: rtl/dbg_ctl_mbp.sv
// dbg_ctl_mbp: multi-breakpoint debug controller with counted single-step.
// Optional feature macro DBG_CYCLE_CNT_EN adds a free-running unstalled-cycle
// counter readable with command 0x0f and clearable with command 0x10.
module dbg_ctl_mbp #(
    parameter int NUM_BP       = 4,
    parameter int STEP_W       = 16,
    parameter int DRAIN_CYCLES = 1
) (
    input logic          clk,
    input logic          rst,
    dbg_ctl_mbp_if.slave dbg
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_TRIGGER   = 3'd1,
        S_DRAIN     = 3'd2,
        S_STOPPED   = 3'd3,
        S_STEP      = 3'd4,
        S_STEP_DONE = 3'd5
    } state_t;

    state_t              r_state, w_nextState;
    logic [2:0]          r_reason;
    logic [7:0]          r_hitIdx;
    logic [STEP_W-1:0]   r_stepCnt, r_stepParam;
    logic [31:0]         r_lastPc;
    logic [DW-1:0]       r_drainCnt;
    logic                r_stopReq, r_contReq, r_stepReq;
    logic [31:0]         r_hostResult;
    logic                r_pcReset;
    logic [NUM_BP-1:0]   r_bpEn;
    logic [3:0]          r_sel;
    logic [31:0]         r_bpAddr [NUM_BP];

    logic                w_bpHit, w_stepTrig, w_abort;
    logic [7:0]          w_hitIdx;
    logic                w_setReason, w_latchHit, w_stepDec, w_loadStep;
    logic [2:0]          w_newReason;
    logic [31:0]         w_result;
    logic                w_flush, w_stall;

`ifdef DBG_CYCLE_CNT_EN
    logic [31:0]         r_cycleCnt;
`endif

    assign dbg.new_pc_value      = dbg.inst_pc_value;
    assign dbg.main_reg_addr     = dbg.host_param[4:0];
    assign dbg.cp0_reg_addr      = dbg.host_param[4:0];
    assign dbg.debugger_mem_addr = dbg.host_param;
    assign dbg.debugger_mem_read = dbg.host_cmd_en && (dbg.host_cmd == 8'h8c);
    assign dbg.host_result       = r_hostResult;
    assign dbg.pc_reset          = r_pcReset;
    assign dbg.flush             = w_flush;
    assign dbg.debug_stall       = w_stall;

    // Breakpoint match; scanning downward leaves the lowest matching slot in w_hitIdx.
    always_comb begin
        w_bpHit  = 1'b0;
        w_hitIdx = 8'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (r_bpEn[i] && (r_bpAddr[i] == dbg.inst_pc_value)) begin
                w_bpHit  = 1'b1;
                w_hitIdx = 8'(i);
            end
        end
    end

    assign w_stepTrig = (dbg.inst_pc_value != 32'd0) && (dbg.inst_pc_value != r_lastPc)
                        && !dbg.inst_in_delayslot;
    assign w_abort    = w_bpHit || r_stopReq;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_nextState;
    end

    // Next-state decision plus the side effects each transition carries.
    always_comb begin
        w_nextState = r_state;
        w_setReason = 1'b0;
        w_newReason = 3'd0;
        w_latchHit  = 1'b0;
        w_stepDec   = 1'b0;
        w_loadStep  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_abort) begin
                    w_nextState = S_TRIGGER;
                    w_setReason = 1'b1;
                    w_newReason = w_bpHit ? 3'd2 : 3'd1;
                    w_latchHit  = 1'b1;
                end
            end
            S_TRIGGER:   w_nextState = S_DRAIN;
            S_DRAIN: begin
                if (r_drainCnt == DW'(DRAIN_CYCLES - 1)) w_nextState = S_STOPPED;
            end
            S_STOPPED: begin
                if (r_contReq) begin
                    w_nextState = S_RUN;
                    w_setReason = 1'b1;
                    w_newReason = 3'd0;
                end else if (r_stepReq) begin
                    w_nextState = S_STEP;
                    w_loadStep  = 1'b1;
                end
            end
            S_STEP: begin
                if (w_abort) begin
                    w_nextState = S_TRIGGER;
                    w_setReason = 1'b1;
                    w_newReason = w_bpHit ? 3'd2 : 3'd1;
                    w_latchHit  = 1'b1;
                end else if (w_stepTrig) begin
                    if (r_stepCnt == STEP_W'(1)) begin
                        w_nextState = S_STEP_DONE;
                        w_setReason = 1'b1;
                        w_newReason = 3'd3;
                    end else begin
                        w_stepDec = 1'b1;
                    end
                end
            end
            S_STEP_DONE: w_nextState = S_DRAIN;
            default:     w_nextState = S_RUN;
        endcase
    end

    // Pipeline controls: flush only on the cycle a halt is taken, stall while halted.
    always_comb begin
        w_flush = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_RUN:       w_flush = w_abort;
            S_STEP:      w_flush = w_abort || (w_stepTrig && (r_stepCnt == STEP_W'(1)));
            S_TRIGGER,
            S_DRAIN,
            S_STOPPED,
            S_STEP_DONE: w_stall = 1'b1;
            default: begin
                w_flush = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    // Halt bookkeeping: reason, hit slot, step counter, last stepped PC, drain timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reason   <= 3'd0;
            r_hitIdx   <= 8'd0;
            r_stepCnt  <= '0;
            r_lastPc   <= 32'd0;
            r_drainCnt <= '0;
        end else begin
            if (w_setReason) r_reason <= w_newReason;
            if (w_latchHit)  r_hitIdx <= w_hitIdx;
            if (w_loadStep) begin
                r_stepCnt <= (r_stepParam == '0) ? STEP_W'(1) : r_stepParam;
                r_lastPc  <= dbg.pc_reg_value;
            end else if (w_stepDec) begin
                r_stepCnt <= r_stepCnt - STEP_W'(1);
                r_lastPc  <= dbg.inst_pc_value;
            end
            r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + DW'(1) : '0;
        end
    end

    // Read-data selection for the command presented this cycle.
    always_comb begin
        w_result = 32'd0;
        case (dbg.host_cmd)
            8'h86: w_result = dbg.main_reg_value;
            8'h87: w_result = dbg.cp0_reg_value;
            8'h08: w_result = dbg.hilo_reg_value[63:32];
            8'h09: w_result = dbg.hilo_reg_value[31:0];
            8'h0a: w_result = dbg.pc_reg_value;
            8'h8c: w_result = dbg.debugger_mem_data;
            8'h0e: w_result = {16'd0, r_hitIdx, r_reason, 2'b00, r_state};
`ifdef DBG_CYCLE_CNT_EN
            8'h0f: w_result = r_cycleCnt;
`endif
            default: w_result = 32'd0;
        endcase
    end

    // Registered command decode: control requests, result, PC reset and slot setup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stopReq    <= 1'b0;
            r_contReq    <= 1'b0;
            r_stepReq    <= 1'b0;
            r_stepParam  <= '0;
            r_hostResult <= 32'd0;
            r_pcReset    <= 1'b0;
            r_bpEn       <= '0;
            r_sel        <= 4'd0;
            for (int i = 0; i < NUM_BP; i++) r_bpAddr[i] <= 32'hffff_ffff;
        end else begin
            r_stopReq    <= dbg.host_cmd_en && (dbg.host_cmd == 8'h01);
            r_contReq    <= dbg.host_cmd_en && (dbg.host_cmd == 8'h02);
            r_stepReq    <= dbg.host_cmd_en && (dbg.host_cmd == 8'h0d);
            r_pcReset    <= dbg.host_cmd_en && (dbg.host_cmd == 8'h0b);
            r_hostResult <= dbg.host_cmd_en ? w_result : 32'd0;
            if (dbg.host_cmd_en) begin
                case (dbg.host_cmd)
                    8'h03: r_bpEn <= dbg.host_param[NUM_BP-1:0];
                    8'h04: if ({28'd0, dbg.host_param[3:0]} < 32'(NUM_BP))
                               r_sel <= dbg.host_param[3:0];
                    8'h85: for (int i = 0; i < NUM_BP; i++)
                               if (r_sel == 4'(i)) r_bpAddr[i] <= dbg.host_param;
                    8'h0d: r_stepParam <= dbg.host_param[STEP_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef DBG_CYCLE_CNT_EN
    // Unstalled-cycle counter; a clear command wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              r_cycleCnt <= 32'd0;
        else if (dbg.host_cmd_en && (dbg.host_cmd == 8'h10))  r_cycleCnt <= 32'd0;
        else if (!w_stall)                                    r_cycleCnt <= r_cycleCnt + 32'd1;
    end
`endif
endmodule
